exc_seq: RTL and testbench

Multicycle exception sequencer for the CPU datapath. On an opcode, overflow or divide-by-zero event, it saves the faulting PC to EPC and steers the memory address mux to the fixed exception-vector address (253/254/255). It then waits out memory latency, loads the PC with the zero-extended handler byte, and returns the address mux to PC. It sits beside the main control FSM and owns the memory-address select while busy.

---
 rtl/exc_pkg.sv | 55 +++++
 rtl/exc_prio_enc.sv | 26 ++
 rtl/exc_seq.sv | 132 +++++++++++++
 tb/tb_exc_seq.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// exc_seq shared types: sequencer states, address-mux selects,
// cause codes and exception vector addresses.
package exc_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SAVE = 3'd1,
    S_WAIT = 3'd2,
    S_LOAD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [2:0] IORD_PC  = 3'b000;
  localparam logic [2:0] IORD_OPC = 3'b011;
  localparam logic [2:0] IORD_OVF = 3'b100;
  localparam logic [2:0] IORD_DIV = 3'b101;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OPC  = 2'b01;
  localparam logic [1:0] CAUSE_OVF  = 2'b10;
  localparam logic [1:0] CAUSE_DIV  = 2'b11;

  localparam logic [7:0] VEC_OPC = 8'd253;
  localparam logic [7:0] VEC_OVF = 8'd254;
  localparam logic [7:0] VEC_DIV = 8'd255;

  function automatic logic [2:0] cause2iord(
    input logic [1:0] c
  );
    logic [2:0] s;
    s = IORD_PC;
    case (c)
      CAUSE_OPC: s = IORD_OPC;
      CAUSE_OVF: s = IORD_OVF;
      CAUSE_DIV: s = IORD_DIV;
      default:   s = IORD_PC;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] iord2cause(
    input logic [2:0] s
  );
    logic [1:0] c;
    c = CAUSE_NONE;
    case (s)
      IORD_OPC: c = CAUSE_OPC;
      IORD_OVF: c = CAUSE_OVF;
      IORD_DIV: c = CAUSE_DIV;
      default:  c = CAUSE_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// exc_seq event priority encoder: opcode > overflow > divzero.
// Returns a valid flag and the winning cause code.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       i_opc,
  input  logic       i_ovf,
  input  logic       i_div,
  output logic       o_valid,
  output logic [1:0] o_cause
);

  always_comb begin
    o_valid = 1'b1;
    o_cause = CAUSE_NONE;
    if (i_opc)
      o_cause = CAUSE_OPC;
    else if (i_ovf)
      o_cause = CAUSE_OVF;
    else if (i_div)
      o_cause = CAUSE_DIV;
    else
      o_valid = 1'b0;
  end

endmodule

// File: rtl/exc_seq.sv
// exc_seq: multicycle exception sequencer (EPC save, vector fetch, PC load).
// Optional EXC_CAUSE_REG_EN builds a register holding the last cause.
module exc_seq
  import exc_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  iordmux,
  output logic        epc_wr,
  output logic [31:0] epc_data,
  output logic        pc_wr,
  output logic [31:0] pc_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  cause
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_iordmux;
  logic [2:0]  w_iord_next;
  logic [3:0]  r_cnt;
  logic        w_valid;
  logic [1:0]  w_code;
  logic        w_unused;

  exc_prio_enc u_enc (
    .i_opc   (exc_opcode),
    .i_ovf   (exc_overflow),
    .i_div   (exc_divzero),
    .o_valid (w_valid),
    .o_cause (w_code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    unique case (r_state)
      S_IDLE:  w_next = w_valid ? S_SAVE : S_IDLE;
      S_SAVE:  w_next = S_WAIT;
      S_WAIT:  w_next = (r_cnt == 4'd0) ? S_LOAD : S_WAIT;
      S_LOAD:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    epc_wr = 1'b0;
    pc_wr  = 1'b0;
    done   = 1'b0;
    busy   = 1'b0;
    unique case (r_state)
      S_SAVE: begin
        epc_wr = 1'b1;
        busy   = 1'b1;
      end
      S_WAIT: busy = 1'b1;
      S_LOAD: begin
        pc_wr = 1'b1;
        busy  = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Select is computed from the next state so the mux flop
  // switches on the same edge as the state register.
  always_comb begin
    w_iord_next = IORD_PC;
    if (w_next == S_SAVE)
      w_iord_next = cause2iord(w_code);
    else if (w_next == S_WAIT || w_next == S_LOAD)
      w_iord_next = r_iordmux;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_iordmux <= IORD_PC;
    else
      r_iordmux <= w_iord_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cnt <= 4'd0;
    else if (r_state == S_SAVE)
      r_cnt <= CNT_INIT;
    else if (r_state == S_WAIT && r_cnt != 4'd0)
      r_cnt <= r_cnt - 4'd1;
  end

`ifdef EXC_CAUSE_REG_EN
  logic [1:0] r_cause;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cause <= CAUSE_NONE;
    else if (r_state == S_SAVE)
      r_cause <= iord2cause(r_iordmux);
  end

  assign cause = r_cause;
`else
  assign cause = CAUSE_NONE;
`endif

  assign iordmux  = r_iordmux;
  assign epc_data = pc_in - 32'd4;
  assign pc_data  = {24'b0, mem_rdata[7:0]};
  assign w_unused = ^mem_rdata[31:8];

endmodule

// File: tb/tb_exc_seq.sv
// Directed bench for exc_seq: three instances (MEM_LAT 2, 1, 15)
// share stimulus; expectations are hand-derived constants.
module tb_exc_seq;

  logic        clk;
  logic        reset;
  logic        exc_opcode;
  logic        exc_overflow;
  logic        exc_divzero;
  logic [31:0] pc_in;
  logic [31:0] mem_rdata;

  logic [2:0]  a_iord, b_iord, c_iord;
  logic        a_ew, b_ew, c_ew;
  logic [31:0] a_ed, b_ed, c_ed;
  logic        a_pw, b_pw, c_pw;
  logic [31:0] a_pd, b_pd, c_pd;
  logic        a_busy, b_busy, c_busy;
  logic        a_done, b_done, c_done;
  logic [1:0]  a_cause, b_cause, c_cause;

  int checks = 0;
  int errors = 0;

`ifdef EXC_CAUSE_REG_EN
  localparam logic [1:0] CZ_OPC = 2'b01;
  localparam logic [1:0] CZ_OVF = 2'b10;
`else
  localparam logic [1:0] CZ_OPC = 2'b00;
  localparam logic [1:0] CZ_OVF = 2'b00;
`endif

  exc_seq #(.MEM_LAT(2)) u_a (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
    .exc_divzero(exc_divzero), .pc_in(pc_in), .mem_rdata(mem_rdata),
    .iordmux(a_iord), .epc_wr(a_ew), .epc_data(a_ed),
    .pc_wr(a_pw), .pc_data(a_pd), .busy(a_busy),
    .done(a_done), .cause(a_cause)
  );

  exc_seq #(.MEM_LAT(1)) u_b (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
    .exc_divzero(exc_divzero), .pc_in(pc_in), .mem_rdata(mem_rdata),
    .iordmux(b_iord), .epc_wr(b_ew), .epc_data(b_ed),
    .pc_wr(b_pw), .pc_data(b_pd), .busy(b_busy),
    .done(b_done), .cause(b_cause)
  );

  exc_seq #(.MEM_LAT(15)) u_c (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
    .exc_divzero(exc_divzero), .pc_in(pc_in), .mem_rdata(mem_rdata),
    .iordmux(c_iord), .epc_wr(c_ew), .epc_data(c_ed),
    .pc_wr(c_pw), .pc_data(c_pd), .busy(c_busy),
    .done(c_done), .cause(c_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((a_busy | b_busy | c_busy) && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (a_busy | b_busy | c_busy) begin
      errors++;
      $display("FAIL wait_idle busy=%b%b%b want 000",
               a_busy, b_busy, c_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    exc_opcode = 1'b0;
    exc_overflow = 1'b0;
    exc_divzero = 1'b0;
    pc_in = 32'd0;
    mem_rdata = 32'd0;
    step();
    step();
    checks++;
    if ({a_iord, a_ew, a_pw, a_busy, a_done, a_cause} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outs got %b want 0",
               {a_iord, a_ew, a_pw, a_busy, a_done, a_cause});
    end
    checks++;
    if ({b_busy, c_busy, b_iord, c_iord} !== 8'd0) begin
      errors++;
      $display("FAIL reset_other got %b want 0",
               {b_busy, c_busy, b_iord, c_iord});
    end
    reset = 1'b1;
    step();
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy got %b want 0", a_busy);
    end
  endtask

  task automatic test_overflow();
    int nb, nio, npc, nd, k;
    wait_idle();
    pc_in = 32'h0000_0040;
    mem_rdata = 32'hAB12_3480;
    exc_overflow = 1'b1;
    step();
    exc_overflow = 1'b0;
    checks++;
    if (a_ew !== 1'b1 || a_ed !== 32'h0000_003C) begin
      errors++;
      $display("FAIL ovf_epc got wr=%b d=%h want 1 0000003c", a_ew, a_ed);
    end
    checks++;
    if (a_iord !== 3'b100) begin
      errors++;
      $display("FAIL ovf_iord_save got %b want 100", a_iord);
    end
    nb = 0; nio = 0; npc = 0; nd = 0; k = 0;
    while (a_busy && k < 40) begin
      nb++;
      if (a_iord == 3'b100) nio++;
      if (a_pw) begin
        npc++;
        checks++;
        if (a_pd !== 32'h0000_0080) begin
          errors++;
          $display("FAIL ovf_pc_data got %h want 00000080", a_pd);
        end
      end
      if (a_done) begin
        nd++;
        checks++;
        if (a_iord !== 3'b000 || a_cause !== CZ_OVF) begin
          errors++;
          $display("FAIL ovf_done got iord=%b cause=%b want 000 %b",
                   a_iord, a_cause, CZ_OVF);
        end
      end
      step();
      k++;
    end
    checks++;
    if (nb != 5 || nio != 4 || npc != 1 || nd != 1) begin
      errors++;
      $display("FAIL ovf_counts got busy=%0d iord=%0d pcwr=%0d done=%0d want 5 4 1 1",
               nb, nio, npc, nd);
    end
  endtask

  task automatic test_all_three();
    int k;
    int nd;
    wait_idle();
    pc_in = 32'h0000_1000;
    exc_opcode = 1'b1;
    exc_overflow = 1'b1;
    exc_divzero = 1'b1;
    step();
    exc_opcode = 1'b0;
    exc_overflow = 1'b0;
    exc_divzero = 1'b0;
    checks++;
    if (a_iord !== 3'b011 || b_iord !== 3'b011 || a_ew !== 1'b1) begin
      errors++;
      $display("FAIL prio_iord got a=%b b=%b ew=%b want 011 011 1",
               a_iord, b_iord, a_ew);
    end
    k = 0;
    nd = 0;
    while (a_busy && k < 40) begin
      if (a_done) begin
        nd++;
        checks++;
        if (a_cause !== CZ_OPC) begin
          errors++;
          $display("FAIL prio_cause got %b want %b", a_cause, CZ_OPC);
        end
      end
      step();
      k++;
    end
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL prio_done got %0d want 1", nd);
    end
  endtask

  task automatic test_divzero_wrap();
    wait_idle();
    pc_in = 32'h0000_0000;
    exc_divzero = 1'b1;
    step();
    exc_divzero = 1'b0;
    checks++;
    if (a_ed !== 32'hFFFF_FFFC || a_ew !== 1'b1) begin
      errors++;
      $display("FAIL div_wrap got wr=%b d=%h want 1 fffffffc", a_ew, a_ed);
    end
    checks++;
    if (a_iord !== 3'b101) begin
      errors++;
      $display("FAIL div_iord got %b want 101", a_iord);
    end
  endtask

  task automatic test_ignore_wait();
    int k, npc, nopc;
    wait_idle();
    pc_in = 32'h0000_0100;
    exc_overflow = 1'b1;
    step();
    exc_overflow = 1'b0;
    step();
    exc_opcode = 1'b1;
    k = 0; npc = 0; nopc = 0;
    while (a_busy && k < 40) begin
      if (k == 1) exc_opcode = 1'b0;
      if (a_pw) npc++;
      if (a_iord == 3'b011) nopc++;
      if (a_done) begin
        checks++;
        if (a_cause !== CZ_OVF) begin
          errors++;
          $display("FAIL ign_cause got %b want %b", a_cause, CZ_OVF);
        end
      end
      step();
      k++;
    end
    checks++;
    if (npc != 1 || nopc != 0) begin
      errors++;
      $display("FAIL ign_counts got pcwr=%0d opcsel=%0d want 1 0", npc, nopc);
    end
    step();
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_dropped busy got %b want 0", a_busy);
    end
  endtask

  task automatic test_mem_lat();
    int nb1, nb15, np1, np15;
    wait_idle();
    pc_in = 32'h0000_0008;
    mem_rdata = 32'h0000_00C5;
    exc_divzero = 1'b1;
    step();
    exc_divzero = 1'b0;
    nb1 = 0; nb15 = 0; np1 = 0; np15 = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 8) mem_rdata = 32'hFFFF_FF3A;
      if (b_busy) nb1++;
      if (c_busy) nb15++;
      if (b_pw) begin
        np1++;
        checks++;
        if (k != 2 || b_pd !== 32'h0000_00C5) begin
          errors++;
          $display("FAIL lat1_load got k=%0d d=%h want 2 000000c5", k, b_pd);
        end
      end
      if (c_pw) begin
        np15++;
        checks++;
        if (k != 16 || c_pd !== 32'h0000_003A) begin
          errors++;
          $display("FAIL lat15_load got k=%0d d=%h want 16 0000003a", k, c_pd);
        end
      end
      step();
    end
    checks++;
    if (nb1 != 4 || np1 != 1) begin
      errors++;
      $display("FAIL lat1_busy got %0d pcwr=%0d want 4 1", nb1, np1);
    end
    checks++;
    if (nb15 != 18 || np15 != 1) begin
      errors++;
      $display("FAIL lat15_busy got %0d pcwr=%0d want 18 1", nb15, np15);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    wait_idle();
    pc_in = 32'h0000_0200;
    exc_divzero = 1'b1;
    step();
    k = 0;
    while (!a_done && k < 40) begin
      step();
      k++;
    end
    checks++;
    if (a_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done got %b want 1", a_done);
    end
    step();
    checks++;
    if (a_busy !== 1'b0 || a_iord !== 3'b000) begin
      errors++;
      $display("FAIL b2b_idle got busy=%b iord=%b want 0 000", a_busy, a_iord);
    end
    step();
    exc_divzero = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_ew !== 1'b1 || a_iord !== 3'b101) begin
      errors++;
      $display("FAIL b2b_resave got busy=%b ew=%b iord=%b want 1 1 101",
               a_busy, a_ew, a_iord);
    end
  endtask

  task automatic test_reset_mid();
    int npc, nbusy;
    wait_idle();
    pc_in = 32'h0000_0300;
    exc_overflow = 1'b1;
    step();
    exc_overflow = 1'b0;
    step();
    checks++;
    if (a_busy !== 1'b1 || a_iord !== 3'b100) begin
      errors++;
      $display("FAIL rmid_wait got busy=%b iord=%b want 1 100", a_busy, a_iord);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({a_iord, a_ew, a_pw, a_busy, a_done, a_cause} !== 9'd0) begin
      errors++;
      $display("FAIL rmid_async got %b want 0",
               {a_iord, a_ew, a_pw, a_busy, a_done, a_cause});
    end
    step();
    reset = 1'b1;
    npc = 0;
    nbusy = 0;
    for (int k = 0; k < 20; k++) begin
      if (a_pw | b_pw | c_pw) npc++;
      if (a_busy | b_busy | c_busy) nbusy++;
      step();
    end
    checks++;
    if (npc != 0 || nbusy != 0) begin
      errors++;
      $display("FAIL rmid_after got pcwr=%0d busy=%0d want 0 0", npc, nbusy);
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_all_three();
    test_divzero_wrap();
    test_ignore_wait();
    test_mem_lat();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
